// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, widths and helpers for the UART TX arbiter.
`default_nettype none

package uart_arb_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int TMO_CNT_W   = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_NEXT = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; first set request at or after ptr_i, wrapping.
`default_nettype none

module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  int k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(ptr_i) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (req_i[k]) begin
        idx_o = IW'(k);
        any_o = 1'b1;
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one UART transmitter among NUM_REQ requesters.
// Optional packet timeout enabled by defining UART_ARB_TIMEOUT_EN.
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*NB_DATA-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_last,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [NB_DATA-1:0]         o_tx_data,
  output logic                       o_tx_start,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int IW = clog2(NUM_REQ);

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               last_q, last_d;
  logic               seen_q, seen_d;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [IW-1:0]      w_arb_idx;
  logic               w_arb_any;
  logic [IW-1:0]      w_sel_idx;
  logic [NB_DATA-1:0] w_sel_data;
  logic [IW-1:0]      w_ptr_next;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_tmo;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (w_arb_gnt),
    .idx_o (w_arb_idx),
    .any_o (w_arb_any)
  );

  assign w_sel_idx  = (state_q == S_IDLE) ? w_arb_idx : owner_q;
  assign w_sel_data = i_req_data[w_sel_idx*NB_DATA +: NB_DATA];
  assign w_ptr_next = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
  logic                 tmo_q;

  assign w_tmo = (state_q == S_NEXT) && !i_req_valid[owner_q] &&
                 (cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == S_NEXT && !i_req_valid[owner_q] && !w_tmo) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= w_tmo;
    end
  end

  assign o_timeout = tmo_q;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TMO_CNT_W'(TIMEOUT_CYCLES);
  assign w_tmo        = 1'b0;
  assign o_timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    seen_d  = seen_q;
    w_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (w_arb_any) begin
          owner_d = w_arb_idx;
          grant_d = w_arb_gnt;
          data_d  = w_sel_data;
          last_d  = i_req_last[w_arb_idx];
          seen_d  = 1'b0;
          w_ready = w_arb_gnt;
          state_d = S_LOAD;
        end
      end
      // The transmitter must be seen idle before its busy edge counts as acceptance.
      S_LOAD: begin
        if (i_tx_done) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          seen_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = w_ptr_next;
            state_d = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (i_req_valid[owner_q]) begin
          data_d  = w_sel_data;
          last_d  = i_req_last[owner_q];
          seen_d  = 1'b0;
          w_ready = grant_q;
          state_d = S_LOAD;
        end else if (w_tmo) begin
          grant_d = '0;
          ptr_d   = w_ptr_next;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
      seen_q  <= seen_d;
    end
  end

  // Ready is decoded from live inputs, so it is masked while reset is held.
  assign o_req_ready = w_ready & {NUM_REQ{~i_rst}};
  assign o_grant     = grant_q;
  assign o_tx_data   = data_q;
  assign o_tx_start  = (state_q == S_LOAD);
  assign o_busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors with hand-computed expectations for uart_tx_arbiter.
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_req_valid;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_last;
  logic [3:0]  o_req_ready;
  logic [3:0]  o_grant;
  logic [7:0]  o_tx_data;
  logic        o_tx_start;
  logic        i_tx_done;
  logic        o_busy;
  logic        o_timeout;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .NB_DATA        (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_grant     (o_grant),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .i_tx_done   (i_tx_done),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_grant"}, o_grant, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_start"}, o_tx_start, 0);
    chk({tag, "_ready"}, o_req_ready, 0);
    chk({tag, "_tmo"}, o_timeout, 0);
  endtask

  // Offer one byte from requester r and run a well-behaved transmitter handshake.
  task automatic xfer(input int r, input logic [7:0] d, input logic lst, input logic [3:0] g);
    i_req_valid[r]      = 1'b1;
    i_req_data[r*8 +: 8] = d;
    i_req_last[r]       = lst;
    #1;
    chk("ready_pulse", o_req_ready, g);
    tick();
    i_req_valid[r] = 1'b0;
    chk("tx_start_hi", o_tx_start, 1);
    chk("tx_data", o_tx_data, d);
    chk("grant", o_grant, g);
    chk("ready_one_cycle", o_req_ready, 0);
    tick();
    i_tx_done = 1'b0;
    tick();
    chk("tx_start_lo", o_tx_start, 0);
    chk("lock_no_ready", o_req_ready, 0);
    i_tx_done = 1'b1;
    tick();
  endtask

  initial begin
    i_rst       = 1'b1;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    i_tx_done   = 1'b1;
    tick();
    chk_idle_outputs("reset");
    chk("reset_data", o_tx_data, 0);
    i_rst = 1'b0;
    tick();

    // Single three-byte packet from requester 1.
    xfer(1, 8'hA5, 1'b0, 4'b0010);
    chk("pkt1_mid_grant", o_grant, 4'b0010);
    chk("pkt1_mid_busy", o_busy, 1);
    xfer(1, 8'h3C, 1'b0, 4'b0010);
    xfer(1, 8'h7E, 1'b1, 4'b0010);
    chk("pkt1_release_grant", o_grant, 0);
    chk("pkt1_release_busy", o_busy, 0);
    chk("pkt1_data_held", o_tx_data, 8'h7E);

    // Reset while requester 3 is mid-packet with another byte pending.
    xfer(3, 8'h5A, 1'b0, 4'b1000);
    i_req_valid[3] = 1'b1;
    i_req_data[31:24] = 8'hEE;
    i_rst = 1'b1;
    #1;
    chk_idle_outputs("rst_mid");
    chk("rst_mid_data", o_tx_data, 0);
    tick();
    chk_idle_outputs("rst_hold");
    i_req_valid[3] = 1'b0;
    i_rst = 1'b0;
    tick();

    // Contention 0/2 with pointer at 0, then tie again with pointer at 3.
    i_req_valid[2] = 1'b1;
    i_req_data[23:16] = 8'h22;
    i_req_last[2] = 1'b1;
    xfer(0, 8'h11, 1'b1, 4'b0001);
    chk("cont_after0_grant", o_grant, 0);
    xfer(2, 8'h22, 1'b1, 4'b0100);
    i_req_valid[2] = 1'b1;
    i_req_data[23:16] = 8'h44;
    xfer(0, 8'h33, 1'b1, 4'b0001);
    xfer(2, 8'h44, 1'b1, 4'b0100);

    // Packet lock: requester 3 waits for requester 0's whole packet.
    xfer(0, 8'h55, 1'b0, 4'b0001);
    i_req_valid[3] = 1'b1;
    i_req_data[31:24] = 8'h99;
    i_req_last[3] = 1'b1;
    #1;
    chk("lock_next_ready", o_req_ready, 0);
    chk("lock_next_grant", o_grant, 4'b0001);
    xfer(0, 8'h66, 1'b1, 4'b0001);
    xfer(3, 8'h99, 1'b1, 4'b1000);

    // Transmitter busy at capture: start held until done toggles 1 then 0.
    i_tx_done = 1'b0;
    i_req_valid[1] = 1'b1;
    i_req_data[15:8] = 8'hC3;
    i_req_last[1] = 1'b1;
    #1;
    chk("hs_ready", o_req_ready, 4'b0010);
    tick();
    i_req_valid[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("hs_start_held", o_tx_start, 1);
      chk("hs_data_held", o_tx_data, 8'hC3);
      chk("hs_no_ready", o_req_ready, 0);
      tick();
    end
    i_tx_done = 1'b1;
    tick();
    chk("hs_start_after_idle", o_tx_start, 1);
    i_tx_done = 1'b0;
    tick();
    chk("hs_start_dropped", o_tx_start, 0);
    i_tx_done = 1'b1;
    tick();
    chk("hs_release_grant", o_grant, 0);
    chk("hs_release_busy", o_busy, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // Owner abandons its packet after one byte.
    xfer(2, 8'h77, 1'b0, 4'b0100);
    for (int i = 0; i < 15; i++) begin
      chk("tmo_early", o_timeout, 0);
      chk("tmo_grant_held", o_grant, 4'b0100);
      tick();
    end
    tick();
    chk("tmo_pulse", o_timeout, 1);
    chk("tmo_grant", o_grant, 0);
    chk("tmo_busy", o_busy, 0);
    tick();
    chk("tmo_pulse_end", o_timeout, 0);
    i_req_valid[2] = 1'b1;
    i_req_valid[3] = 1'b1;
    i_req_last[3]  = 1'b1;
    #1;
    chk("tmo_ptr_advanced", o_req_ready, 4'b1000);
    i_req_valid = '0;
    tick();
`else
    xfer(2, 8'h77, 1'b0, 4'b0100);
    for (int i = 0; i < 20; i++) tick();
    chk("no_tmo_pulse", o_timeout, 0);
    chk("no_tmo_grant", o_grant, 4'b0100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
